radar_sweep_ctrl: RTL and testbench

Sequencer and framebuffer-port owner for the radar display path. Steps the sweep angle, waits until the sample FIFO holds a radial line, starts the line writer and waits for it to finish. Runs full-frame clears through its own address counter. Muxes the clear engine and the line writer onto the single RAM write port, so the writer never drives the RAM directly.

---
 rtl/radar_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_ctrl.sv
// Radar sweep sequencer and framebuffer write-port owner.
// Steps the sweep angle, hands radial lines to the line writer, runs
// full-frame clears and muxes clear/draw writes onto one registered RAM port.
module radar_sweep_ctrl #(
    parameter int          WIDTH         = 640,
    parameter int          HEIGHT        = 480,
    parameter int          ANGLE_MAX     = 179,
    parameter logic [2:0]  CLEAR_COLOR   = 3'b000,
    parameter int          CLEAR_ON_WRAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear_req,
    input  logic        line_ready,
    input  logic        draw_done,
    input  logic        wr_req_draw,
    input  logic [18:0] wr_addr_draw,
    input  logic [2:0]  wr_data_draw,
    output logic [8:0]  angle,
    output logic        draw_start,
    output logic        ram_we,
    output logic [18:0] ram_addr,
    output logic [2:0]  ram_data,
    output logic        busy,
    output logic        clearing,
    output logic        sweep_done
);

    localparam logic [18:0] LAST_ADDR  = 19'(WIDTH * HEIGHT - 1);
    localparam logic [8:0]  ANGLE_LAST = 9'(ANGLE_MAX);
    localparam logic        WRAP_CLEAR = (CLEAR_ON_WRAP != 0);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_LINE,
        DRAW,
        ADVANCE
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        clear_pending;
    logic [18:0] clr_cnt;

    logic        enter_clear;
    logic        start_line;
    logic        wrap;
    logic        we_d;
    logic [18:0] addr_d;
    logic [2:0]  data_d;

    assign busy     = (state != IDLE);
    assign clearing = (state == CLEAR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode plus the RAM port mux (clear engine vs line writer).
    always_comb begin
        state_d     = state;
        enter_clear = 1'b0;
        start_line  = 1'b0;
        wrap        = 1'b0;
        we_d        = 1'b0;
        addr_d      = ram_addr;
        data_d      = ram_data;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (clear_pending) begin
                        state_d     = CLEAR;
                        enter_clear = 1'b1;
                    end else begin
                        state_d = WAIT_LINE;
                    end
                end
            end
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_cnt;
                data_d = CLEAR_COLOR;
                if (clr_cnt == LAST_ADDR) begin
                    state_d = enable ? WAIT_LINE : IDLE;
                end
            end
            WAIT_LINE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (clear_pending) begin
                    state_d     = CLEAR;
                    enter_clear = 1'b1;
                end else if (line_ready) begin
                    state_d    = DRAW;
                    start_line = 1'b1;
                end
            end
            DRAW: begin
                we_d = wr_req_draw;
                if (wr_req_draw) begin
                    addr_d = wr_addr_draw;
                    data_d = wr_data_draw;
                end
                if (draw_done) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                wrap    = (angle == ANGLE_LAST);
                state_d = WAIT_LINE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sweep angle, clear bookkeeping, one-cycle pulses and registered RAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle         <= '0;
            clr_cnt       <= '0;
            clear_pending <= 1'b1;
            draw_start    <= 1'b0;
            sweep_done    <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_data      <= '0;
        end else begin
            draw_start <= start_line;
            sweep_done <= wrap;
            ram_we     <= we_d;
            ram_addr   <= addr_d;
            ram_data   <= data_d;

            // A request landing on the entry cycle is served by the clear
            // that is starting, so entry wins over a new request.
            if (enter_clear) begin
                clear_pending <= 1'b0;
            end else if ((clear_req && state != CLEAR) || (wrap && WRAP_CLEAR)) begin
                clear_pending <= 1'b1;
            end

            if (enter_clear) begin
                clr_cnt <= '0;
            end else if (state == CLEAR && clr_cnt != LAST_ADDR) begin
                clr_cnt <= clr_cnt + 19'd1;
            end

            if (state == ADVANCE) begin
                angle <= wrap ? '0 : angle + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Scoreboard bench for radar_sweep_ctrl: a transaction-level model predicts
// the ordered stream of RAM writes, draw_start angles and sweep wraps.
module tb_radar_sweep_ctrl;

    localparam int         W    = 8;
    localparam int         H    = 4;
    localparam int         N    = W * H;
    localparam int         AMAX = 179;
    localparam logic [2:0] CLR  = 3'b110;

    localparam int EV_WR    = 0;
    localparam int EV_START = 1;
    localparam int EV_SWEEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear_req;
    logic        line_ready;
    logic        draw_done;
    logic        wr_req_draw;
    logic [18:0] wr_addr_draw;
    logic [2:0]  wr_data_draw;
    logic [8:0]  angle;
    logic        draw_start;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [2:0]  ram_data;
    logic        busy;
    logic        clearing;
    logic        sweep_done;

    radar_sweep_ctrl #(
        .WIDTH(W),
        .HEIGHT(H),
        .ANGLE_MAX(AMAX),
        .CLEAR_COLOR(CLR),
        .CLEAR_ON_WRAP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .clear_req(clear_req),
        .line_ready(line_ready),
        .draw_done(draw_done),
        .wr_req_draw(wr_req_draw),
        .wr_addr_draw(wr_addr_draw),
        .wr_data_draw(wr_data_draw),
        .angle(angle),
        .draw_start(draw_start),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .busy(busy),
        .clearing(clearing),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [18:0] addr;
        logic [2:0]  data;
        logic [8:0]  ang;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  m_angle = 0;
    bit  m_pending = 1'b1;
    int  clr_run = 0;

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic void push(int k, logic [18:0] a, logic [2:0] d, logic [8:0] g);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.ang  = g;
        sb.push_back(e);
    endfunction

    function automatic void push_clear();
        for (int i = 0; i < N; i++) push(EV_WR, 19'(i), CLR, 9'd0);
        m_pending = 1'b0;
    endfunction

    task automatic expect_ev(int k, logic [18:0] a, logic [2:0] d, logic [8:0] g);
        ev_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0d angle %0d, required no event",
                     k, a, d, g);
            return;
        end
        e = sb.pop_front();
        if (e.kind != k || e.addr !== a || e.data !== d || e.ang !== g) begin
            n_fail++;
            $display("FAIL event: got kind %0d addr %0d data %0d angle %0d, required kind %0d addr %0d data %0d angle %0d",
                     k, a, d, g, e.kind, e.addr, e.data, e.ang);
        end
    endtask

    // Monitor: every observable output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            clr_run = 0;
        end else begin
            if (clearing) begin
                clr_run++;
            end else if (clr_run != 0) begin
                chk("clear_len", clr_run, N);
                clr_run = 0;
            end
            if (sweep_done) begin
                chk("sweep_angle", int'(angle), 0);
                expect_ev(EV_SWEEP, 19'd0, 3'd0, 9'd0);
            end
            if (ram_we) expect_ev(EV_WR, ram_addr, ram_data, 9'd0);
            if (draw_start) expect_ev(EV_START, 19'd0, 3'd0, angle);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // what: 0 = draw_start high, 1 = clearing high, 2 = clearing low
    task automatic wait_for(int what, int budget);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            tick();
            case (what)
                0:       hit = draw_start;
                1:       hit = clearing;
                default: hit = !clearing;
            endcase
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%0d: got no event in %0d cycles, required one", what, budget);
        end
    endtask

    task automatic run_line(bit inject, bit drop, bit fixed);
        int k;
        repeat ($urandom_range(0, 2)) tick();
        push(EV_START, 19'd0, 3'd0, 9'(m_angle));
        line_ready = 1'b1;
        wait_for(0, 200);
        line_ready = 1'b0;
        clear_req  = inject;
        if (inject) m_pending = 1'b1;
        if (drop) enable = 1'b0;
        k = fixed ? 3 : $urandom_range(0, 5);
        for (int i = 0; i < k; i++) begin
            wr_req_draw  = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            wr_addr_draw = fixed ? 19'(100 + i) : 19'($urandom);
            wr_data_draw = fixed ? 3'b101 : 3'($urandom);
            if (wr_req_draw) push(EV_WR, wr_addr_draw, wr_data_draw, 9'd0);
            tick();
            clear_req   = 1'b0;
            wr_req_draw = 1'b0;
        end
        draw_done    = 1'b1;
        wr_req_draw  = fixed ? 1'b0 : 1'($urandom_range(0, 1));
        wr_addr_draw = 19'($urandom);
        wr_data_draw = 3'($urandom);
        if (wr_req_draw) push(EV_WR, wr_addr_draw, wr_data_draw, 9'd0);
        tick();
        draw_done   = 1'b0;
        wr_req_draw = 1'b0;
        clear_req   = 1'b0;
        if (m_angle == AMAX) begin
            m_angle   = 0;
            m_pending = 1'b1;
            push(EV_SWEEP, 19'd0, 3'd0, 9'd0);
        end else begin
            m_angle++;
        end
        if (m_pending && enable) begin
            push_clear();
            wait_for(1, 10);
            if ($urandom_range(0, 1) == 1) begin
                clear_req = 1'b1;
                tick();
                clear_req = 1'b0;
            end
            wait_for(2, N + 10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        clear_req    = 1'b0;
        line_ready   = 1'b0;
        draw_done    = 1'b0;
        wr_req_draw  = 1'b0;
        wr_addr_draw = '0;
        wr_data_draw = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_clearing", int'(clearing), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_angle", int'(angle), 0);
        chk("rst_draw_start", int'(draw_start), 0);
        chk("rst_sweep_done", int'(sweep_done), 0);

        push_clear();
        enable = 1'b1;
        rst    = 1'b0;
        wait_for(1, 10);
        wait_for(2, N + 10);
        tick();
        chk("wait_busy", int'(busy), 1);
        chk("wait_ram_we", int'(ram_we), 0);

        for (int i = 0; i < 200; i++) begin
            run_line((i == 5) || ($urandom_range(0, 15) == 0), (i == 50), (i == 0));
            if (i == 50) begin
                repeat (4) tick();
                chk("idle_busy", int'(busy), 0);
                chk("idle_clearing", int'(clearing), 0);
                wr_req_draw  = 1'b1;
                wr_addr_draw = 19'd77;
                tick();
                wr_req_draw = 1'b0;
                repeat (2) tick();
                enable = 1'b1;
                if (m_pending) begin
                    push_clear();
                    wait_for(1, 10);
                    wait_for(2, N + 10);
                end
            end
        end

        // Reset in the middle of a clear: the next enable restarts from address 0.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_clear();
        wait_for(1, 10);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("midclr_ram_we", int'(ram_we), 0);
        chk("midclr_angle", int'(angle), 0);
        chk("midclr_busy", int'(busy), 0);
        sb.delete();
        m_angle   = 0;
        m_pending = 1'b1;
        repeat (2) tick();
        push_clear();
        rst = 1'b0;
        wait_for(1, 10);
        wait_for(2, N + 10);
        run_line(1'b0, 1'b0, 1'b0);

        repeat (5) tick();
        chk("scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
